// File: rtl/hazard_mc.sv
// Hazard unit for the 5-stage MIPS pipeline with multi-cycle mul/div tracking.
// Define HAZARD_PERF_EN to add saturating stall performance counters.
module hazard_mc #(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_all,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              mdstartE,
  input  logic              mdopE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushE,
  output logic              flushM,
  output logic              md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lw,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_md
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Counter preload is N-2: one cycle is spent in IDLE, one more at cnt==0.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lwstall;
  logic             w_brstall;
  logic             w_mdstall;

  function automatic logic fwd_d(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] wreg_m,
                                 input logic              rw_m,
                                 input logic              m2r_m);
    return (src != '0) && (src == wreg_m) && rw_m && !m2r_m;
  endfunction

  // M stage has priority over W since it holds the younger result.
  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wreg_m,
                                       input logic              rw_m,
                                       input logic [REG_AW-1:0] wreg_w,
                                       input logic              rw_w);
    logic [1:0] sel;
    sel = 2'b00;
    if ((src != '0) && (src == wreg_m) && rw_m)
      sel = 2'b10;
    else if ((src != '0) && (src == wreg_w) && rw_w)
      sel = 2'b01;
    return sel;
  endfunction

  assign forwardaD = fwd_d(rsD, writeregM, regwriteM, memtoregM);
  assign forwardbD = fwd_d(rtD, writeregM, regwriteM, memtoregM);
  assign forwardaE = fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE = fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW);

  assign w_lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));

  assign w_brstall = branchD &&
    ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
     (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

  // A mul/div stalls while it is being accepted or counting; reset and flush_all kill it.
  always_comb begin
    w_mdstall = 1'b0;
    if (rst_n && !flush_all) begin
      case (r_state)
        S_IDLE:  w_mdstall = mdstartE;
        S_BUSY:  w_mdstall = (r_cnt != '0);
        default: w_mdstall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (flush_all) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdstartE) begin
            r_cnt   <= mdopE ? DIV_LOAD : MUL_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_ONE;
          else
            r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign md_busy = (r_state == S_BUSY);
  assign stallF  = w_lwstall || w_brstall || w_mdstall;
  assign stallD  = w_lwstall || w_brstall || w_mdstall;
  assign stallE  = w_mdstall;
  assign flushM  = w_mdstall;
  // Holding E takes precedence over bubbling it.
  assign flushE  = (w_lwstall || w_brstall) && !w_mdstall;

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lw <= '0;
      perf_br <= '0;
      perf_md <= '0;
    end else begin
      if (w_lwstall)
        perf_lw <= sat_inc(perf_lw);
      // Cycles where both stall causes coincide are charged to the load.
      if (w_brstall && !w_lwstall)
        perf_br <= sat_inc(perf_br);
      if (w_mdstall)
        perf_md <= sat_inc(perf_md);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Directed scoreboard bench for hazard_mc: forwarding, load/branch stalls,
// mul/div tracking, flush_all and asynchronous reset; perf counters if enabled.
module tb_hazard_mc;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_all;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic              branchD, regwriteE, memtoregE, mdstartE, mdopE;
  logic              regwriteM, memtoregM, regwriteW;
  logic              forwardaD, forwardbD, stallF, stallD, stallE, flushE, flushM, md_busy;
  logic [1:0]        forwardaE, forwardbE;
`ifdef HAZARD_PERF_EN
  logic [1:0]        perf_lw, perf_br, perf_md;
`endif

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  hazard_mc #(.REG_AW(REG_AW), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(2)) dut (
`else
  hazard_mc #(.REG_AW(REG_AW), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .flush_all(flush_all),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .mdstartE(mdstartE), .mdopE(mdopE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .perf_lw(perf_lw), .perf_br(perf_br), .perf_md(perf_md)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wire [11:0] w_obs = {forwardaD, forwardbD, forwardaE, forwardbE,
                       stallF, stallD, stallE, flushE, flushM, md_busy};

  function automatic logic [11:0] ev(input logic fad, input logic fbd,
                                     input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fe, input logic fm, input logic bz);
    return {fad, fbd, fae, fbe, sf, sd, se, fe, fm, bz};
  endfunction

  task automatic push(input string tag, input logic [31:0] e, input logic [31:0] m);
    sb.push_back('{tag, e, m});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    sb_t t;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
      return;
    end
    t = sb.pop_front();
    assert ((obs & t.mask) === (t.exp & t.mask)) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", t.tag, obs & t.mask, t.exp & t.mask);
    end
  endtask

  // Inputs were driven just after a rising edge; compare on the falling edge.
  task automatic step(input string tag, input logic [11:0] e, input logic [11:0] m);
    push(tag, {20'b0, e}, {20'b0, m});
    @(negedge clk);
    pop_cmp({20'b0, w_obs});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush_all = 0; rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0;
    writeregE = 0; regwriteE = 0; memtoregE = 0; mdstartE = 0; mdopE = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 0; regwriteW = 0;
  endtask

  localparam logic [11:0] ALL  = 12'hFFF;
  localparam logic [11:0] NOBZ = 12'hFFE;

  initial begin
    int n_st;
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    step("reset_state", 12'h000, ALL);
    rst_n = 1;

    // Forwarding into E
    rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    step("fwdE_M", ev(0,0,2'b10,2'b10,0,0,0,0,0,0), ALL);
    regwriteM = 0;
    step("fwdE_W", ev(0,0,2'b01,2'b01,0,0,0,0,0,0), ALL);
    rsE = 0; rtE = 0;
    step("fwdE_r0", ev(0,0,2'b00,2'b00,0,0,0,0,0,0), ALL);
    clear_inputs();

    // Load-use
    memtoregE = 1; rtE = 5; rsD = 5;
    step("lw_rs", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    rtE = 0;
    step("lw_rt0", ev(0,0,0,0,0,0,0,0,0,0), ALL);
    rtE = 5; rsD = 0; rtD = 5;
    step("lw_rt", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    clear_inputs();

    // Branch sequence
    branchD = 1; rsD = 7; regwriteE = 1; writeregE = 7;
    step("br_E", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    regwriteE = 0; writeregE = 0; memtoregM = 1; regwriteM = 1; writeregM = 7;
    step("br_Mload", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    memtoregM = 0;
    step("br_fwd", ev(1,0,0,0,0,0,0,0,0,0), ALL);
    clear_inputs();
    branchD = 1; rsD = 0; regwriteE = 1; writeregE = 0;
    step("br_r0", ev(0,0,0,0,0,0,0,0,0,0), ALL);
    clear_inputs();

    // 4-cycle multiply with a concurrent load-use in cycle 2
    mdstartE = 1; mdopE = 0;
    step("mul_c1", ev(0,0,0,0,1,1,1,0,1,0), ALL);
    memtoregE = 1; rtE = 5; rsD = 5;
    step("mul_c2_lw", ev(0,0,0,0,1,1,1,0,1,1), ALL);
    memtoregE = 0; rtE = 0; rsD = 0;
    step("mul_c3", ev(0,0,0,0,1,1,1,0,1,1), ALL);
    step("mul_c4", ev(0,0,0,0,0,0,0,0,0,0), NOBZ);
    // Back-to-back multiply restarts from IDLE
    step("b2b_c1", ev(0,0,0,0,1,1,1,0,1,0), ALL);
    for (int i = 0; i < 2; i++)
      step("b2b_busy", ev(0,0,0,0,1,1,1,0,1,1), ALL);
    step("b2b_c4", ev(0,0,0,0,0,0,0,0,0,0), NOBZ);
    mdstartE = 0;
    step("mul_idle", ev(0,0,0,0,0,0,0,0,0,0), ALL);

    // Divide aborted by flush_all in cycle 10
    mdstartE = 1; mdopE = 1;
    step("div_c1", ev(0,0,0,0,1,1,1,0,1,0), ALL);
    for (int i = 0; i < 8; i++)
      step("div_busy", ev(0,0,0,0,1,1,1,0,1,1), ALL);
    flush_all = 1;
    step("div_flush", ev(0,0,0,0,0,0,0,0,0,1), ALL);
    flush_all = 0; mdstartE = 0;
    step("div_after_flush", ev(0,0,0,0,0,0,0,0,0,0), ALL);
    flush_all = 1; mdstartE = 1;
    step("flush_vs_start", ev(0,0,0,0,0,0,0,0,0,0), ALL);
    flush_all = 0; mdstartE = 0;
    step("flush_vs_start_nx", ev(0,0,0,0,0,0,0,0,0,0), ALL);

    // Full divide: stall length must be DIV_CYCLES-1
    mdstartE = 1; mdopE = 1; n_st = 0;
    push("div_stall_len", 32'd31, 32'hFFFF_FFFF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stallE) break;
      n_st++;
      @(posedge clk); #1;
    end
    pop_cmp(n_st);
    @(posedge clk); #1;
    mdstartE = 0;
    step("div_done_idle", ev(0,0,0,0,0,0,0,0,0,0), ALL);

    // Asynchronous reset in cycle 5 of a divide
    mdstartE = 1; mdopE = 1;
    step("div2_c1", ev(0,0,0,0,1,1,1,0,1,0), ALL);
    for (int i = 0; i < 3; i++)
      step("div2_busy", ev(0,0,0,0,1,1,1,0,1,1), ALL);
    push("rst_mid", 32'h0, 32'h0000_0FFF);
    rst_n = 0;
    #1;
    pop_cmp({20'b0, w_obs});
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    step("post_rst", ev(0,0,0,0,0,0,0,0,0,0), ALL);

`ifdef HAZARD_PERF_EN
    memtoregE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 2; i++)
      step("perf_lw_cyc", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    clear_inputs();
    mdstartE = 1;
    for (int i = 0; i < 3; i++)
      step("perf_mul", ev(0,0,0,0,1,1,1,0,1,0), 12'hFFE);
    step("perf_mul_c4", ev(0,0,0,0,0,0,0,0,0,0), NOBZ);
    mdstartE = 0;
    push("perf_lw_2", 32'd2, 32'hFFFF_FFFF);
    push("perf_md_3", 32'd3, 32'hFFFF_FFFF);
    push("perf_br_0", 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    pop_cmp({30'b0, perf_lw});
    pop_cmp({30'b0, perf_md});
    pop_cmp({30'b0, perf_br});
    @(posedge clk); #1;
    memtoregE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 2; i++)
      step("perf_lw_cyc2", ev(0,0,0,0,1,1,0,1,0,0), ALL);
    clear_inputs();
    mdstartE = 1;
    for (int i = 0; i < 4; i++)
      step("perf_mul2", ev(0,0,0,0,0,0,0,0,0,0), 12'h000);
    mdstartE = 0;
    push("perf_lw_sat", 32'd3, 32'hFFFF_FFFF);
    push("perf_md_sat", 32'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    pop_cmp({30'b0, perf_lw});
    pop_cmp({30'b0, perf_md});
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
